data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressable, little-endian data memory for the RISC-V datapath load/store stage; successor to the fixed 64-byte, doubleword-only data memory.
- Adds RV64 access sizes (B/H/W/D) with sign/zero extension, alignment and bounds checking, and a valid/ready request/response handshake with a registered response.
- Sits between the EX/MEM stage and the MEM/WB register; the core stalls on req_ready/resp_valid.

Parameters:
- XLEN, 64, data width in bits; must be 64 (size encoding 3 = doubleword).
- DEPTH_BYTES, 256, memory size in bytes; power of two, minimum 8.
- INIT_BYTE, 8'd13, value loaded into every byte at time zero (simulation initial block only).
- ADDR_W, 64, request address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and for size 3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data; low 2^size bytes are used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  XLEN  load result; 0 for stores and on error.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State goes to IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 1.
  - Memory contents are not cleared.
- FSM states:
  - IDLE: req_ready = 1, resp_valid = 0.
  - RESP: req_ready = 0, resp_valid = 1.
- Transitions:
  - IDLE goes to RESP on an accept edge (req_valid & req_ready).
  - RESP goes to IDLE on resp_ready. Otherwise RESP holds, keeping resp_rdata and resp_err stable.
- Latency and throughput:
  - A request accepted at edge N gives resp_valid high from after edge N until the edge where resp_ready is seen.
  - Minimum 1 cycle; peak throughput is one access per 2 cycles.
- Error check, evaluated at the accept edge:
  - Misaligned when req_addr mod 2^size != 0.
  - Out of range when req_addr + 2^size > DEPTH_BYTES, computed without 64-bit wrap, so an address of 2^64-1 is an error.
  - On error: no memory write, resp_err = 1, resp_rdata = 0.
- Store:
  - Bytes addr .. addr + 2^size - 1 are written at the accept edge with req_wdata[8i+7:8i] to addr + i.
  - No other bytes change.
  - Response has resp_rdata = 0 and resp_err = 0.
- Load:
  - 2^size bytes are read at the accept edge, assembled little-endian, then extended to XLEN.
  - Sign extension uses bit 8*2^size - 1 unless req_unsigned is set.
  - Result is registered into resp_rdata.
- Request inputs are sampled only at the accept edge; changes while in RESP are ignored.
- req_valid held high across the RESP cycle is not accepted until the FSM returns to IDLE; the next accept is the edge after the RESP to IDLE transition.
- Reset asserted in RESP:
  - The response is dropped and the FSM returns to IDLE.
  - A store accepted before reset remains written.
- Unused address bits above log2(DEPTH_BYTES) only take part in the range check.

Test Plan:
- Word store then load:
  - Store size 2 to addr 0x10 with wdata 0xFFFF_FFFF_8000_0001, then signed word load from 0x10 -> resp_rdata = 0xFFFF_FFFF_8000_0001.
  - Unsigned word load from 0x10 -> 0x0000_0000_8000_0001.
- Byte lane isolation:
  - After reset-time init, store byte 0xAB to addr 0x21.
  - Doubleword load from 0x20 -> 0x0D0D_0D0D_0D0D_AB0D.
  - Signed byte load from 0x21 -> 0xFFFF_FFFF_FFFF_FFAB.
- Misaligned and out-of-range access:
  - Half store to 0x03 -> resp_err = 1, memory unchanged (doubleword load from 0x00 -> 0x0D0D_0D0D_0D0D_0D0D).
  - Doubleword load from 0xFC with DEPTH_BYTES = 256 -> resp_err = 1, resp_rdata = 0.
- Backpressure:
  - Load with resp_ready held 0 for 3 cycles -> resp_valid stays 1, resp_rdata stable, req_ready = 0 throughout.
  - A second req_valid is accepted only after resp_ready = 1 and the return to IDLE.
- Back-to-back handshake:
  - req_valid held 1 and resp_ready held 1 -> accepts on alternating edges, one resp_valid pulse per access.
- Reset mid-response:
  - Assert rst_n = 0 while in RESP after a store of 0x1234 (size 1) to 0x40 -> resp_valid drops to 0 immediately and req_ready = 1.
  - After release, half load from 0x40 -> 0x0000_0000_0000_1234.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable little-endian data memory for the load/store stage.
// Supports B/H/W/D accesses with sign/zero extension, alignment and bounds checks, and a
// valid/ready request/response handshake with a registered response.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      request present
//   req_ready      controller can accept a request (high in IDLE)
//   req_write      1 = store, 0 = load
//   req_size       0 = byte, 1 = half, 2 = word, 3 = double
//   req_unsigned   zero-extend loads when 1, sign-extend when 0
//   req_addr       byte address
//   req_wdata      store data, low 2^size bytes used
//   resp_valid     response present (high in RESP)
//   resp_ready     consumer accepts response
//   resp_rdata     load result; 0 for stores and on error
//   resp_err       misaligned or out-of-range access
module data_memory_ctrl #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter logic [7:0]  INIT_BYTE   = 8'd13,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic [7:0]        mem [DEPTH_BYTES];
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic [3:0]        nbytes;
    logic              misaligned;
    logic              out_of_range;
    logic              access_err;
    logic [IDX_W-1:0]  base_idx;
    logic [63:0]       raw_data;
    logic [XLEN-1:0]   load_val;
    logic [7:0]        byte_en;

`ifndef SYNTHESIS
    initial begin
        for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
            mem[i] = INIT_BYTE;
        end
    end
`endif

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;
    assign base_idx   = req_addr[IDX_W-1:0];

    always_comb begin
        nbytes = 4'd1;
        unique case (req_size)
            2'd0: nbytes = 4'd1;
            2'd1: nbytes = 4'd2;
            2'd2: nbytes = 4'd4;
            2'd3: nbytes = 4'd8;
            default: nbytes = 4'd1;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = req_addr[0];
            2'd2: misaligned = |req_addr[1:0];
            2'd3: misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // One extra bit so addresses near the top of the address space cannot wrap past the check.
    assign out_of_range = ({1'b0, req_addr} + (ADDR_W + 1)'(nbytes)) > (ADDR_W + 1)'(DEPTH_BYTES);
    assign access_err   = misaligned || out_of_range;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_en[i] = (4'(i) < nbytes);
        end
    end

    // Gather 8 bytes from the base; only the low 2^size of them are meaningful.
    always_comb begin
        raw_data = '0;
        for (int i = 0; i < 8; i++) begin
            raw_data[8*i +: 8] = mem[base_idx + IDX_W'(i)];
        end
    end

    always_comb begin
        load_val = raw_data;
        unique case (req_size)
            2'd0: load_val = {{(XLEN-8){raw_data[7] & ~req_unsigned}}, raw_data[7:0]};
            2'd1: load_val = {{(XLEN-16){raw_data[15] & ~req_unsigned}}, raw_data[15:0]};
            2'd2: load_val = {{(XLEN-32){raw_data[31] & ~req_unsigned}}, raw_data[31:0]};
            2'd3: load_val = raw_data;
            default: load_val = raw_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StResp;
                    err_d   = access_err;
                    rdata_d = (access_err || req_write) ? '0 : load_val;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory is never cleared by reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_write && !access_err) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[base_idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_total = 0;
    int n_bad   = 0;

    data_memory_ctrl #(
        .XLEN        (64),
        .DEPTH_BYTES (256),
        .INIT_BYTE   (8'd13),
        .ADDR_W      (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [63:0] a, input logic [63:0] wd);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    // Single access from IDLE; called 1 time unit after a rising edge.
    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rdata, input logic exp_err);
        set_req(w, sz, u, a, wd);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq({tag, ".valid"}, 64'(resp_valid), 64'd1);
        check_eq({tag, ".rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, ".err"}, 64'(resp_err), 64'(exp_err));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    int pulses;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        set_req(1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        #12;
        check_eq("rst.req_ready", 64'(req_ready), 64'd1);
        check_eq("rst.resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst.resp_rdata", resp_rdata, 64'd0);
        check_eq("rst.resp_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store then signed / unsigned loads; doubleword shows only 4 bytes written
        access("st_w", 1'b1, 2'd2, 1'b0, 64'h10, 64'hFFFF_FFFF_8000_0001, 64'd0, 1'b0);
        access("ld_w_s", 1'b0, 2'd2, 1'b0, 64'h10, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b0);
        access("ld_w_u", 1'b0, 2'd2, 1'b1, 64'h10, 64'd0, 64'h0000_0000_8000_0001, 1'b0);
        access("ld_d_10", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h0D0D_0D0D_8000_0001, 1'b0);

        // Byte lane isolation
        access("st_b", 1'b1, 2'd0, 1'b0, 64'h21, 64'h1234_5678_9ABC_DEAB, 64'd0, 1'b0);
        access("ld_d_20", 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'h0D0D_0D0D_0D0D_AB0D, 1'b0);
        access("ld_b_s", 1'b0, 2'd0, 1'b0, 64'h21, 64'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
        access("ld_b_u", 1'b0, 2'd0, 1'b1, 64'h21, 64'd0, 64'h0000_0000_0000_00AB, 1'b0);
        access("ld_h_s", 1'b0, 2'd1, 1'b0, 64'h20, 64'd0, 64'hFFFF_FFFF_FFFF_AB0D, 1'b0);

        // Misaligned / out-of-range
        access("st_h_mis", 1'b1, 2'd1, 1'b0, 64'h03, 64'hFFFF, 64'd0, 1'b1);
        access("ld_d_00", 1'b0, 2'd3, 1'b0, 64'h00, 64'd0, 64'h0D0D_0D0D_0D0D_0D0D, 1'b0);
        access("ld_d_fc", 1'b0, 2'd3, 1'b0, 64'hFC, 64'd0, 64'd0, 1'b1);
        access("ld_d_f8", 1'b0, 2'd3, 1'b0, 64'hF8, 64'd0, 64'h0D0D_0D0D_0D0D_0D0D, 1'b0);
        access("ld_b_ff", 1'b0, 2'd0, 1'b0, 64'hFF, 64'd0, 64'h0000_0000_0000_000D, 1'b0);
        access("ld_b_100", 1'b0, 2'd0, 1'b0, 64'h100, 64'd0, 64'd0, 1'b1);
        access("ld_b_max", 1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1);
        access("st_d_oor", 1'b1, 2'd3, 1'b0, 64'h1_0000_0000, 64'hDEAD, 64'd0, 1'b1);
        access("ld_d_00b", 1'b0, 2'd3, 1'b0, 64'h00, 64'd0, 64'h0D0D_0D0D_0D0D_0D0D, 1'b0);

        // Backpressure: response held, request changes ignored, req_valid kept high
        set_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        set_req(1'b0, 2'd0, 1'b1, 64'h21, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp.valid", 64'(resp_valid), 64'd1);
            check_eq("bp.ready", 64'(req_ready), 64'd0);
            check_eq("bp.rdata", resp_rdata, 64'h0D0D_0D0D_8000_0001);
            @(posedge clk);
            #1;
        end
        check_eq("bp.hold", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq("bp.idle_valid", 64'(resp_valid), 64'd0);
        check_eq("bp.idle_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("bp.second_valid", 64'(resp_valid), 64'd1);
        check_eq("bp.second_rdata", resp_rdata, 64'h0000_0000_0000_00AB);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: accepts on alternating edges
        set_req(1'b0, 2'd2, 1'b1, 64'h10, 64'd0);
        req_valid = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_eq("b2b.valid", 64'(resp_valid), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (resp_valid) begin
                pulses++;
                check_eq("b2b.rdata", resp_rdata, 64'h0000_0000_8000_0001);
            end
        end
        check_eq("b2b.pulses", 64'(pulses), 64'd4);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("b2b.idle", 64'(req_ready), 64'd1);

        // Reset while in RESP after a half store
        set_req(1'b1, 2'd1, 1'b0, 64'h40, 64'h1234);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("rr.valid", 64'(resp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rr.drop_valid", 64'(resp_valid), 64'd0);
        check_eq("rr.drop_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access("rr.ld_h", 1'b0, 2'd1, 1'b1, 64'h40, 64'd0, 64'h0000_0000_0000_1234, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
